adder_op_seq: RTL and testbench
===============================

Name: adder_op_seq

Overview:
- Upstream operand sequencer for the 8-bit add/subtract adder.
- Receives a 3-byte command frame (command, A, B) over a valid/ready byte stream and drives the adder's A_in/B_in/Sel_in with a coherent operand set.
- Waits a fixed settle time, then captures the adder's 9-bit Rez_out and returns it downstream over a valid/ready result port.

Parameters:
- SETTLE_CYCLES, 1, cycles between operand update and Rez_in capture; legal range 1..15; 4-bit counter.

Ports:
- Clk_in  input  1  clock, rising edge.
- Rst_n_in  input  1  reset, asynchronous, active-low.
- Data_in  input  8  frame byte stream.
- Data_valid_in  input  1  Data_in valid.
- Data_ready_out  output  1  sequencer accepts byte; transfer = valid & ready at rising edge.
- A_out  output  8  to adder A_in.
- B_out  output  8  to adder B_in.
- Sel_out  output  1  to adder Sel_in; 0 = add, 1 = subtract.
- Rez_in  input  9  from adder Rez_out.
- Res_out  output  9  captured result.
- Res_valid_out  output  1  Res_out valid.
- Res_ready_in  input  1  downstream accepts result.
- Busy_out  output  1  frame in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Asserting Rst_n_in forces the state immediately, independent of the clock.
- Reset values: state IDLE, all outputs 0 (including Data_ready_out), shadow A/B/Sel regs 0, settle counter 0.
- Data_ready_out is registered. It rises on the first rising edge after Rst_n_in deasserts.
- FSM states: IDLE, GET_A, GET_B, SETTLE, RESULT.
- IDLE: Data_ready_out=1. On transfer, latch Data_in[0] into the Sel shadow (bits 7:1 ignored) -> GET_A.
- GET_A: Data_ready_out=1. On transfer, latch the A shadow -> GET_B.
- GET_B: Data_ready_out=1. On transfer, at that same edge A_out, B_out (=Data_in) and Sel_out update together from the shadows, counter loads SETTLE_CYCLES-1, Data_ready_out drops -> SETTLE.
- A_out/B_out/Sel_out never change mid-frame. They hold the last issued operands until the next GET_B transfer.
- SETTLE: Data_ready_out=0. Counter decrements each cycle. When the counter is 0, on that edge Res_out<=Rez_in and Res_valid_out<=1 -> RESULT.
- Latency (SETTLE_CYCLES=1): B byte accepted at edge k; Res_valid_out high after edge k+1.
- RESULT: Res_valid_out and Res_out are held stable until Res_ready_in=1 at an edge. At that edge Res_valid_out<=0 and Data_ready_out<=1 -> IDLE.
- No same-cycle bypass: a new command byte is accepted no earlier than the edge after result handoff.
- Res_out keeps its last value after handoff until the next capture.
- Res_ready_in outside RESULT is ignored.
- Data_valid_in during SETTLE/RESULT: not accepted; the upstream holds the byte.
- Data_valid_in low mid-frame: FSM waits indefinitely in GET_A/GET_B; no timeout.
- Data_in is don't-care when Data_valid_in=0.
- Rez_in is passed through unmodified (width 9, no sign extension or saturation). Arithmetic, including the subtract encoding, is owned by the adder.
- Reset mid-frame or mid-result: abort, discard the partial frame and the pending result, outputs return to reset values.
- Busy_out = (state != IDLE), registered alongside the state.

Test Plan:
- Reset: hold Rst_n_in=0 for 3 cycles, then release -> all outputs 0 during reset; Data_ready_out=1 one edge after release; Busy_out=0.
- Add: bytes 0x00,0x64,0x32 back-to-back, Res_ready_in=1 -> A_out=0x64, B_out=0x32, Sel_out=0 after the third transfer; Res_out=9'h096 with a one-cycle Res_valid_out pulse, two edges after the B byte.
- Add overflow: 0x00,0xFF,0xFF -> Res_out=9'h1FE; next frame accepted the cycle after handoff.
- Subtract: 0xFF,0x10,0x20 -> Sel_out=1 (bits 7:1 ignored); Res_out equals the adder's A-B value, 9'h1F0 for the 9-bit two's-complement difference.
- Backpressure and gaps:
  - Stimulus: 2 idle cycles inserted between bytes; Res_ready_in held low 5 cycles.
  - Response: FSM waits in place; Res_valid_out=1 and Res_out stable for all 5 cycles; Data_ready_out=0; Data_valid_in ignored; handoff on the first Res_ready_in=1.
- Reset mid-frame and settle: SETTLE_CYCLES=4, assert Rst_n_in low asynchronously in GET_B, then run a full frame 0x00,0x01,0x02 -> no result from the aborted frame; Res_out=9'h003 five edges after the B byte.

Source files
------------

// File: rtl/adder_op_seq.sv
// Operand sequencer for the 8-bit add/subtract adder: takes a (cmd, A, B) byte frame,
// presents a coherent operand set, waits SETTLE_CYCLES, then returns the adder result.
module adder_op_seq #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       Clk_in,
    input  logic       Rst_n_in,
    input  logic [7:0] Data_in,
    input  logic       Data_valid_in,
    output logic       Data_ready_out,
    output logic [7:0] A_out,
    output logic [7:0] B_out,
    output logic       Sel_out,
    input  logic [8:0] Rez_in,
    output logic [8:0] Res_out,
    output logic       Res_valid_out,
    input  logic       Res_ready_in,
    output logic       Busy_out,
    output logic [2:0] Dbg_state_out
);

    // Handshake: a byte moves on Data_in when Data_valid_in & Data_ready_out at a rising
    // edge; a result moves on Res_out when Res_valid_out & Res_ready_in at a rising edge.
    // Valid is never withdrawn before ready is seen, and the holder keeps the data stable.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_SETTLE = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic       r_sel_sh;
    logic [7:0] r_a_sh;
    logic [3:0] r_cnt;
    logic       r_data_ready;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_sel;
    logic [8:0] r_res;
    logic       r_res_valid;
    logic       r_busy;

    logic       w_xfer;

    assign w_xfer = Data_valid_in & r_data_ready;

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_state      <= S_IDLE;
            r_sel_sh     <= 1'b0;
            r_a_sh       <= 8'h00;
            r_cnt        <= 4'h0;
            r_data_ready <= 1'b0;
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_sel        <= 1'b0;
            r_res        <= 9'h000;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_data_ready <= 1'b1;
                    if (w_xfer) begin
                        r_sel_sh <= Data_in[0];
                        r_state  <= S_GET_A;
                        r_busy   <= 1'b1;
                    end
                end
                S_GET_A: begin
                    if (w_xfer) begin
                        r_a_sh  <= Data_in;
                        r_state <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    // All three operands switch on the same edge so the adder never
                    // sees a mix of old and new inputs.
                    if (w_xfer) begin
                        r_a          <= r_a_sh;
                        r_b          <= Data_in;
                        r_sel        <= r_sel_sh;
                        r_cnt        <= LP_CNT_LOAD;
                        r_data_ready <= 1'b0;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'h0) begin
                        r_res       <= Rez_in;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt - 4'h1;
                    end
                end
                S_RESULT: begin
                    if (Res_ready_in) begin
                        r_res_valid  <= 1'b0;
                        r_data_ready <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_data_ready <= 1'b0;
                    r_res_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign Data_ready_out = r_data_ready;
    assign A_out          = r_a;
    assign B_out          = r_b;
    assign Sel_out        = r_sel;
    assign Res_out        = r_res;
    assign Res_valid_out  = r_res_valid;
    assign Busy_out       = r_busy;
    assign Dbg_state_out  = r_state;

endmodule

// File: tb/tb_adder_op_seq.sv
// Directed bench for adder_op_seq: unit 0 uses SETTLE_CYCLES=1, unit 1 uses SETTLE_CYCLES=4,
// each driving a small behavioural adder on its operand outputs.
module tb_adder_op_seq;

    logic            clk;
    logic [1:0]      rst_n;
    logic [1:0][7:0] data;
    logic [1:0]      valid;
    logic [1:0]      res_ready;
    wire  [1:0]      ready;
    wire  [1:0][7:0] a_o;
    wire  [1:0][7:0] b_o;
    wire  [1:0]      sel_o;
    wire  [1:0][8:0] rez;
    wire  [1:0][8:0] res;
    wire  [1:0]      res_valid;
    wire  [1:0]      busy;
    wire  [1:0][2:0] dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: 9-bit sum or two's-complement difference
    assign rez[0] = sel_o[0] ? ({1'b0, a_o[0]} - {1'b0, b_o[0]}) : ({1'b0, a_o[0]} + {1'b0, b_o[0]});
    assign rez[1] = sel_o[1] ? ({1'b0, a_o[1]} - {1'b0, b_o[1]}) : ({1'b0, a_o[1]} + {1'b0, b_o[1]});

    adder_op_seq #(.SETTLE_CYCLES(1)) dut0 (
        .Clk_in(clk), .Rst_n_in(rst_n[0]), .Data_in(data[0]), .Data_valid_in(valid[0]),
        .Data_ready_out(ready[0]), .A_out(a_o[0]), .B_out(b_o[0]), .Sel_out(sel_o[0]),
        .Rez_in(rez[0]), .Res_out(res[0]), .Res_valid_out(res_valid[0]),
        .Res_ready_in(res_ready[0]), .Busy_out(busy[0]), .Dbg_state_out(dbg[0])
    );

    adder_op_seq #(.SETTLE_CYCLES(4)) dut1 (
        .Clk_in(clk), .Rst_n_in(rst_n[1]), .Data_in(data[1]), .Data_valid_in(valid[1]),
        .Data_ready_out(ready[1]), .A_out(a_o[1]), .B_out(b_o[1]), .Sel_out(sel_o[1]),
        .Rez_in(rez[1]), .Res_out(res[1]), .Res_valid_out(res_valid[1]),
        .Res_ready_in(res_ready[1]), .Busy_out(busy[1]), .Dbg_state_out(dbg[1])
    );

    // Scoreboard-style checker
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        int n;
        data[u]  = b;
        valid[u] = 1'b1;
        n = 0;
        while (ready[u] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ready[u] !== 1'b1) check_eq("send_timeout", 32'(ready[u]), 32'd1);
        step();
        valid[u] = 1'b0;
        data[u]  = 8'h00;
    endtask

    task automatic send_gapped(input int u, input logic [7:0] b, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            step();
            check_eq("gap_busy", 32'(busy[u]), 32'd1);
            check_eq("gap_ready", 32'(ready[u]), 32'd1);
            check_eq("gap_a_hold", 32'(a_o[u]), 32'h10);
        end
        send_byte(u, b);
    endtask

    initial begin
        rst_n     = 2'b00;
        data      = '0;
        valid     = 2'b00;
        res_ready = 2'b00;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_ready", 32'(ready[0]), 32'd0);
            check_eq("rst_busy", 32'(busy[0]), 32'd0);
            check_eq("rst_res_valid", 32'(res_valid[0]), 32'd0);
            check_eq("rst_ops", {15'd0, sel_o[0], a_o[0], b_o[0]}, 32'd0);
            check_eq("rst_res", 32'(res[0]), 32'd0);
        end
        rst_n = 2'b11;
        #1;
        check_eq("rel_ready_pre", 32'(ready[0]), 32'd0);
        step();
        check_eq("rel_ready", 32'(ready[0]), 32'd1);
        check_eq("rel_busy", 32'(busy[0]), 32'd0);

        // Add 0x64 + 0x32
        res_ready[0] = 1'b1;
        send_byte(0, 8'h00);
        send_byte(0, 8'h64);
        send_byte(0, 8'h32);
        check_eq("add_a", 32'(a_o[0]), 32'h64);
        check_eq("add_b", 32'(b_o[0]), 32'h32);
        check_eq("add_sel", 32'(sel_o[0]), 32'd0);
        check_eq("add_ready_low", 32'(ready[0]), 32'd0);
        check_eq("add_valid_early", 32'(res_valid[0]), 32'd0);
        step();
        check_eq("add_valid", 32'(res_valid[0]), 32'd1);
        check_eq("add_res", 32'(res[0]), 32'h096);
        step();
        check_eq("add_pulse_end", 32'(res_valid[0]), 32'd0);
        check_eq("add_ready_back", 32'(ready[0]), 32'd1);
        check_eq("add_res_keep", 32'(res[0]), 32'h096);

        // Overflow 0xFF + 0xFF; next command offered while the result is pending
        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        send_byte(0, 8'hFF);
        step();
        check_eq("ovf_valid", 32'(res_valid[0]), 32'd1);
        check_eq("ovf_res", 32'(res[0]), 32'h1FE);
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        step();
        check_eq("ovf_handoff", 32'(res_valid[0]), 32'd0);
        check_eq("no_bypass_busy", 32'(busy[0]), 32'd0);
        check_eq("no_bypass_ready", 32'(ready[0]), 32'd1);
        step();
        check_eq("next_accepted", 32'(dbg[0]), 32'd1);
        valid[0] = 1'b0;

        // Subtract 0x10 - 0x20 (command 0xFF, upper bits ignored)
        send_byte(0, 8'h10);
        send_byte(0, 8'h20);
        check_eq("sub_sel", 32'(sel_o[0]), 32'd1);
        check_eq("sub_ops", {16'd0, a_o[0], b_o[0]}, 32'h1020);
        step();
        check_eq("sub_res", 32'(res[0]), 32'h1F0);
        check_eq("sub_valid", 32'(res_valid[0]), 32'd1);
        step();

        // Gaps between bytes and result backpressure
        res_ready[0] = 1'b0;
        send_byte(0, 8'h00);
        send_gapped(0, 8'h05, 2);
        send_gapped(0, 8'h07, 2);
        check_eq("bp_ops", {15'd0, sel_o[0], a_o[0], b_o[0]}, 32'h0507);
        step();
        data[0]  = 8'hAA;
        valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(res_valid[0]), 32'd1);
            check_eq("bp_res", 32'(res[0]), 32'h00C);
            check_eq("bp_ready", 32'(ready[0]), 32'd0);
            check_eq("bp_state", 32'(dbg[0]), 32'd4);
            step();
        end
        valid[0]     = 1'b0;
        res_ready[0] = 1'b1;
        check_eq("bp_still_valid", 32'(res_valid[0]), 32'd1);
        step();
        check_eq("bp_handoff", 32'(res_valid[0]), 32'd0);
        check_eq("bp_idle", 32'(busy[0]), 32'd0);

        // SETTLE_CYCLES=4 unit: async reset in GET_B, then a full frame
        res_ready[1] = 1'b1;
        send_byte(1, 8'h00);
        send_byte(1, 8'h09);
        check_eq("mid_state", 32'(dbg[1]), 32'd2);
        check_eq("mid_busy", 32'(busy[1]), 32'd1);
        #3;
        rst_n[1] = 1'b0;
        #1;
        check_eq("async_busy", 32'(busy[1]), 32'd0);
        check_eq("async_ready", 32'(ready[1]), 32'd0);
        check_eq("async_state", 32'(dbg[1]), 32'd0);
        #1;
        rst_n[1] = 1'b1;
        step();
        check_eq("s4_ready", 32'(ready[1]), 32'd1);
        check_eq("s4_no_result", 32'(res_valid[1]), 32'd0);
        send_byte(1, 8'h00);
        send_byte(1, 8'h01);
        send_byte(1, 8'h02);
        check_eq("s4_ops", {15'd0, sel_o[1], a_o[1], b_o[1]}, 32'h0102);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("s4_settle", 32'(res_valid[1]), 32'd0);
        end
        step();
        check_eq("s4_valid", 32'(res_valid[1]), 32'd1);
        check_eq("s4_res", 32'(res[1]), 32'h003);
        step();
        check_eq("s4_handoff", 32'(res_valid[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
